// File: rtl/data_bus_bridge_if.sv
// Data-bus side of the MIPS M-stage bridge.
//
// Handshake: the master raises bus_req together with bus_wr, bus_addr and
// bus_wdata, and holds all four stable until the slave answers with bus_gnt.
// A request is accepted on the rising edge of a cycle where bus_req and bus_gnt
// are both high. Reads are split: after the read is accepted the master drops
// bus_req and waits for a single bus_rvalid pulse carrying bus_rdata.
// bus_gnt and bus_rvalid are ignored whenever the master is not expecting them.
`timescale 1ns/1ps

interface data_bus_bridge_if #(
    parameter int AW = 32
) ();
    logic          bus_req;
    logic          bus_wr;
    logic [AW-1:0] bus_addr;
    logic [31:0]   bus_wdata;
    logic          bus_gnt;
    logic          bus_rvalid;
    logic [31:0]   bus_rdata;

    // Bridge side: issues requests, consumes grants and read data.
    modport master (
        output bus_req,
        output bus_wr,
        output bus_addr,
        output bus_wdata,
        input  bus_gnt,
        input  bus_rvalid,
        input  bus_rdata
    );

    // Memory / interconnect side.
    modport slave (
        input  bus_req,
        input  bus_wr,
        input  bus_addr,
        input  bus_wdata,
        output bus_gnt,
        output bus_rvalid,
        output bus_rdata
    );
endinterface

// File: rtl/data_bus_bridge.sv
// data_bus_bridge: turns the MIPS M-stage load/store requests into a
// req/gnt/rvalid data-bus transaction.
// Stores are posted into a small circular write buffer and drained in the
// background, so a store only stalls the core when the buffer is full.
// Loads stall the core until the buffer has drained and the read data has come
// back; draining first gives read-after-write ordering with no address compare.
`timescale 1ns/1ps

module data_bus_bridge #(
    parameter int WB_DEPTH = 4,
    parameter int AW       = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    // core side (M stage)
    input  logic                      memenM,
    input  logic                      memwriteM,
    input  logic [AW-1:0]             aluoutM,
    input  logic [31:0]               writedataM,
    output logic [31:0]               readdataM,
    output logic                      stallM,
    // data bus
    data_bus_bridge_if.master         bus,
    // debug visibility of the bus FSM and the write buffer
    output logic [1:0]                dbgState,
    output logic [$clog2(WB_DEPTH):0] dbgCount,
    output logic                      dbgDone
);
    localparam int PW = $clog2(WB_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(WB_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        RDW  = 2'd3
    } busStateT;

    busStateT state;
    busStateT nextState;

    // write buffer storage and bookkeeping
    logic [AW-1:0] wbAddr [WB_DEPTH];
    logic [31:0]   wbData [WB_DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;

    // load completion flag: high for the single cycle the core consumes readdataM
    logic done;

    logic          loadReq;
    logic          storeReq;
    logic          wbFull;
    logic          push;
    logic          pop;
    logic          capture;
    logic [AW-1:0] wordAddr;
    logic          addrLowUnused;

    // The two low address bits select a byte within the word and play no part
    // on a word-wide bus.
    assign addrLowUnused = ^aluoutM[1:0];
    assign wordAddr      = {aluoutM[AW-1:2], 2'b00};

    assign loadReq  = memenM & ~memwriteM;
    assign storeReq = memenM & memwriteM;

    // Fullness comes from the registered count only, so a pop in the same
    // cycle never lets a push into a full buffer.
    assign wbFull = (count == FULL);
    assign push   = storeReq & ~wbFull;

    // Stall a load until its data has been captured, and a store while the
    // buffer is full. Held low while reset is asserted.
    assign stallM = rst & ((loadReq & ~done) | (storeReq & wbFull));

    assign dbgState = state;
    assign dbgCount = count;
    assign dbgDone  = done;

    // Bus FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Bus FSM next state and bus outputs; writes are always served before reads.
    always_comb begin
        nextState     = state;
        bus.bus_req   = 1'b0;
        bus.bus_wr    = 1'b0;
        bus.bus_addr  = '0;
        bus.bus_wdata = '0;
        pop           = 1'b0;
        capture       = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    nextState = WR;
                end else if (loadReq && !done) begin
                    nextState = RD;
                end
            end
            WR: begin
                // head entry cannot move while waiting, so the request is stable
                bus.bus_req   = 1'b1;
                bus.bus_wr    = 1'b1;
                bus.bus_addr  = wbAddr[head];
                bus.bus_wdata = wbData[head];
                if (bus.bus_gnt) begin
                    pop       = 1'b1;
                    nextState = IDLE;
                end
            end
            RD: begin
                // the core is stalled, so aluoutM is held for the whole request
                bus.bus_req  = 1'b1;
                bus.bus_addr = wordAddr;
                if (bus.bus_gnt) begin
                    nextState = RDW;
                end
            end
            RDW: begin
                if (bus.bus_rvalid) begin
                    capture   = 1'b1;
                    nextState = IDLE;
                end
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Write buffer pointers and occupancy; simultaneous push and pop cancel out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Write buffer payload; entries are only meaningful between head and tail.
    always_ff @(posedge clk) begin
        if (push) begin
            wbAddr[tail] <= wordAddr;
            wbData[tail] <= writedataM;
        end
    end

    // Load data capture and the one-cycle done pulse that releases the stall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            readdataM <= '0;
            done      <= 1'b0;
        end else begin
            if (capture) begin
                readdataM <= bus.bus_rdata;
            end
            done <= capture;
        end
    end
endmodule

// File: tb/tb_data_bus_bridge.sv
// Testbench for data_bus_bridge: directed steps plus randomized load/store
// traffic against a program-order memory model and a randomized bus slave.
`timescale 1ns/1ps

module tb_data_bus_bridge;
    localparam int WB_DEPTH = 4;
    localparam int AW       = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic                      memenM;
    logic                      memwriteM;
    logic [AW-1:0]             aluoutM;
    logic [31:0]               writedataM;
    logic [31:0]               readdataM;
    logic                      stallM;
    logic [1:0]                dbgState;
    logic [$clog2(WB_DEPTH):0] dbgCount;
    logic                      dbgDone;

    data_bus_bridge_if #(.AW(AW)) bus ();

    // bus inputs come either from the random slave or from directed steps
    logic        manualMode;
    logic        mGnt;
    logic        mRvalid;
    logic [31:0] mRdata;
    logic        sGnt;
    logic        sRvalid;
    logic [31:0] sRdata;

    assign bus.bus_gnt    = manualMode ? mGnt    : sGnt;
    assign bus.bus_rvalid = manualMode ? mRvalid : sRvalid;
    assign bus.bus_rdata  = manualMode ? mRdata  : sRdata;

    data_bus_bridge #(.WB_DEPTH(WB_DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .memenM     (memenM),
        .memwriteM  (memwriteM),
        .aluoutM    (aluoutM),
        .writedataM (writedataM),
        .readdataM  (readdataM),
        .stallM     (stallM),
        .bus        (bus),
        .dbgState   (dbgState),
        .dbgCount   (dbgCount),
        .dbgDone    (dbgDone)
    );

    // ---------------- scoreboard state ----------------
    int          compared   = 0;
    int          mismatched = 0;
    logic [63:0] expQ [$];          // {word addr, data} of accepted stores, program order
    logic [31:0] refMem [256];      // memory as the program sees it
    logic [31:0] busMem [256];      // memory as the bus slave holds it

    // slave configuration (written by the main sequence only)
    int gntMin = 0;
    int gntMax = 0;
    int rvMin  = 0;
    int rvMax  = 0;

    // slave statistics (written by the slave only)
    int wrReqCycles = 0;
    int rdGrants    = 0;
    int maxCount    = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- bus slave with random grant / rvalid delays ----------------
    initial begin : slave
        int          gntLeft;
        int          rvLeft;
        logic        inReq;
        logic        rdPending;
        logic [7:0]  rdIdx;
        logic [63:0] exp;
        for (int i = 0; i < 256; i++) busMem[i] = '0;
        sGnt = 1'b0; sRvalid = 1'b0; sRdata = '0;
        gntLeft = 0; rvLeft = 0; inReq = 1'b0; rdPending = 1'b0; rdIdx = '0;
        forever begin
            @(negedge clk);
            sGnt    = 1'b0;
            sRvalid = 1'b0;
            if (int'(dbgCount) > maxCount) maxCount = int'(dbgCount);
            if (bus.bus_req && bus.bus_wr) wrReqCycles++;
            if (!rst || manualMode) begin
                inReq     = 1'b0;
                rdPending = 1'b0;
            end else if (rdPending) begin
                if (rvLeft == 0) begin
                    sRvalid   = 1'b1;
                    sRdata    = busMem[rdIdx];
                    rdPending = 1'b0;
                end else begin
                    rvLeft--;
                end
            end else if (bus.bus_req) begin
                if (!inReq) begin
                    inReq   = 1'b1;
                    gntLeft = int'($urandom_range(gntMax, gntMin));
                    // every store accepted earlier must already be on the bus
                    if (!bus.bus_wr) check("read_after_writes_drained", 64'(expQ.size()), 64'd0);
                end
                if (gntLeft == 0) begin
                    sGnt  = 1'b1;
                    inReq = 1'b0;
                    if (bus.bus_wr) begin
                        check("write_expected", 64'(expQ.size() != 0), 64'd1);
                        if (expQ.size() != 0) begin
                            exp = expQ.pop_front();
                            check("write_addr_data", {bus.bus_addr, bus.bus_wdata}, exp);
                        end
                        busMem[bus.bus_addr[9:2]] = bus.bus_wdata;
                    end else begin
                        rdPending = 1'b1;
                        rdIdx     = bus.bus_addr[9:2];
                        rvLeft    = int'($urandom_range(rvMax, rvMin));
                        rdGrants++;
                    end
                end else begin
                    gntLeft--;
                end
            end
        end
    end

    // ---------------- core-side driver tasks ----------------
    task automatic coreIdle(input int n);
        memenM = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic coreStore(input logic [31:0] a, input logic [31:0] d, output int stalls);
        logic accepted;
        accepted   = 1'b0;
        stalls     = 0;
        memenM     = 1'b1;
        memwriteM  = 1'b1;
        aluoutM    = a;
        writedataM = d;
        for (int n = 0; n < 300 && !accepted; n++) begin
            @(negedge clk);
            if (!stallM) begin
                accepted = 1'b1;
                refMem[a[9:2]] = d;
                expQ.push_back({a[31:2], 2'b00, d});
            end else begin
                stalls++;
            end
            @(posedge clk); #1;
        end
        if (!accepted) check("store_timeout", 64'(accepted), 64'd1);
        memenM = 1'b0;
    endtask

    task automatic coreLoad(input logic [31:0] a, output int stalls);
        logic accepted;
        accepted   = 1'b0;
        stalls     = 0;
        memenM     = 1'b1;
        memwriteM  = 1'b0;
        aluoutM    = a;
        writedataM = $urandom;
        for (int n = 0; n < 300 && !accepted; n++) begin
            @(negedge clk);
            if (!stallM) begin
                accepted = 1'b1;
                check("load_data", 64'(readdataM), 64'(refMem[a[9:2]]));
            end else begin
                stalls++;
            end
            @(posedge clk); #1;
        end
        if (!accepted) check("load_timeout", 64'(accepted), 64'd1);
        memenM = 1'b0;
    endtask

    task automatic drain(input string tag);
        logic empty;
        empty  = 1'b0;
        memenM = 1'b0;
        for (int n = 0; n < 600 && !empty; n++) begin
            @(negedge clk);
            empty = (expQ.size() == 0) && (dbgCount == '0) && !bus.bus_req;
            @(posedge clk); #1;
        end
        check({tag, "_drained"}, 64'(empty), 64'd1);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin : main
        int          st;
        int          rdBefore;
        int          wrBefore;
        logic [31:0] a;
        logic [31:0] d;

        for (int i = 0; i < 256; i++) refMem[i] = '0;
        manualMode = 1'b0; mGnt = 1'b0; mRvalid = 1'b0; mRdata = '0;
        rst        = 1'b0;
        memenM     = 1'b1;          // a load held during reset must not stall
        memwriteM  = 1'b0;
        aluoutM    = 32'h44;
        writedataM = '0;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_stallM",    64'(stallM),        64'd0);
        check("rst_bus_req",   64'(bus.bus_req),   64'd0);
        check("rst_bus_wr",    64'(bus.bus_wr),    64'd0);
        check("rst_bus_addr",  64'(bus.bus_addr),  64'd0);
        check("rst_bus_wdata", 64'(bus.bus_wdata), 64'd0);
        check("rst_readdataM", 64'(readdataM),     64'd0);
        check("rst_count",     64'(dbgCount),      64'd0);
        check("rst_state",     64'(dbgState),      64'd0);
        check("rst_done",      64'(dbgDone),       64'd0);
        rst    = 1'b1;
        memenM = 1'b0;
        @(posedge clk); #1;

        // reset while waiting for read data; the late rvalid must be ignored
        manualMode = 1'b1;
        memenM = 1'b1; memwriteM = 1'b0; aluoutM = 32'h40;
        @(negedge clk);
        check("rdw_rst_idle_stall", 64'(stallM), 64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("rdw_rst_rd_req",  64'({bus.bus_req, bus.bus_wr}), 64'b10);
        check("rdw_rst_rd_addr", 64'(bus.bus_addr), 64'h40);
        mGnt = 1'b1;
        @(posedge clk); #1;
        mGnt = 1'b0;
        @(negedge clk);
        check("rdw_rst_rdw_req", 64'(bus.bus_req), 64'd0);
        rst = 1'b0;
        #1;
        check("rdw_rst_state",  64'(dbgState), 64'd0);
        check("rdw_rst_stallM", 64'(stallM),   64'd0);
        check("rdw_rst_req",    64'(bus.bus_req), 64'd0);
        mRvalid = 1'b1;
        mRdata  = 32'hCAFEF00D;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst    = 1'b1;
        memenM = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("rdw_rst_late_rvalid_data",  64'(readdataM), 64'd0);
        check("rdw_rst_late_rvalid_state", 64'(dbgState),  64'd0);
        check("rdw_rst_late_rvalid_req",   64'(bus.bus_req), 64'd0);
        mRvalid    = 1'b0;
        manualMode = 1'b0;
        @(posedge clk); #1;

        // single store, grant on the second request cycle
        gntMin = 1; gntMax = 1;
        wrBefore = wrReqCycles;
        coreStore(32'h100, 32'hDEADBEEF, st);
        check("single_store_stall", 64'(st), 64'd0);
        coreIdle(8);
        @(negedge clk);
        check("single_store_req_cycles", 64'(wrReqCycles - wrBefore), 64'd2);
        check("single_store_count",      64'(dbgCount), 64'd0);
        @(posedge clk); #1;

        // fill the buffer while grants are held off for 6 cycles
        gntMin = 6; gntMax = 6;
        for (int i = 0; i < WB_DEPTH; i++) begin
            coreStore(32'h300 + 32'(4 * i), $urandom, st);
            check("fill_store_no_stall", 64'(st), 64'd0);
        end
        // stores in cycles 0..3, first write request in cycle 2, grant in cycle 8,
        // fifth store presented in cycle 4 and accepted in cycle 9
        coreStore(32'h310, 32'h55AA55AA, st);
        check("fill_fifth_store_stall", 64'(st), 64'd5);
        drain("fill");

        // read after write to the same word
        gntMin = 2; gntMax = 2; rvMin = 1; rvMax = 1;
        coreStore(32'h200, 32'h11223344, st);
        coreLoad(32'h200, st);
        check("raw_readdata", 64'(readdataM), 64'h11223344);
        drain("raw");

        // load latency with empty buffer, immediate grant and rvalid
        gntMin = 0; gntMax = 0; rvMin = 0; rvMax = 0;
        rdBefore = rdGrants;
        coreLoad(32'h103, st);
        check("latency_stall_cycles", 64'(st), 64'd3);
        check("latency_reads",        64'(rdGrants - rdBefore), 64'd1);
        check("latency_readdata",     64'(readdataM), 64'hDEADBEEF);

        // pointer wrap: ten stores with random grant delays
        gntMin = 0; gntMax = 4;
        for (int i = 0; i < 10; i++) begin
            a = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
            d = $urandom;
            coreStore(a, d, st);
        end
        drain("wrap");

        // mixed random traffic
        gntMin = 0; gntMax = 3; rvMin = 0; rvMax = 3;
        for (int i = 0; i < 40; i++) begin
            a = ((32'h40 + 32'($urandom_range(0, 15))) << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 9) < 6) begin
                d = $urandom;
                coreStore(a, d, st);
            end else begin
                coreLoad(a, st);
            end
            if ($urandom_range(0, 3) == 0) coreIdle(int'($urandom_range(1, 3)));
        end
        drain("mixed");
        check("max_count_within_depth", 64'(maxCount <= WB_DEPTH), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // bound on total run time
    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: run exceeded 500000 ns, observed no finish, expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
